// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with mid-bit sampling, first-word-fall-through
// receive FIFO, and sticky framing/overrun flags.
module uart_rx #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 115_200,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_pin,
    input  logic               rd_en,
    input  logic               err_clr,
    output logic [7:0]         rx_byte,
    output logic               rx_empty,
    output logic [FIFO_AW:0]   rx_count,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]    TICK_LAST = CW'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rxs;
    logic [CW-1:0]      tick_cnt;
    logic               tick;
    logic [3:0]         s_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               shift_en;
    logic               stop_tick;
    logic               push;
    logic               frame_evt;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               full;
    logic               pop;
    logic               wr_ok;
    logic               ovr_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rxs     <= rx_meta;
        end
    end

    // Held at zero while idle so the first tick lands DIV cycles after the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s_cnt   <= 4'd0;
            bit_idx <= 3'd0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s_cnt <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == 4'd7) begin
                            s_cnt <= 4'd0;
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd15) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd15) begin
                            state <= rxs ? IDLE : BRK;
                            busy  <= !rxs;
                        end
                    end
                end
                BRK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign shift_en  = (state == DATA) && tick && (s_cnt == 4'd15);
    assign stop_tick = (state == STOP) && tick && (s_cnt == 4'd15);
    assign push      = stop_tick && rxs;
    assign frame_evt = stop_tick && !rxs;

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {rxs, shreg[7:1]};
        end
    end

    assign rx_count = wr_ptr - rd_ptr;
    assign rx_empty = (rx_count == '0);
    assign full     = (rx_count == DEPTH_CNT);
    assign pop      = rd_en && !rx_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the byte.
    assign wr_ok    = push && (!full || pop);
    assign ovr_evt  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rx_byte = rx_empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
